uart_rx_fifo: RTL and testbench

DUT-side UART receiver with an elastic byte buffer. It deserialises 8N1 frames from the `rxd` line into bytes and queues them in a FIFO. It presents them to the core over a valid/ready handshake. It sits between the board/testbench serial line (driven by the UART model's transmitter) and the core's MMIO serial peripheral. Parity checking is optional.

---
 rtl/uart_rx_fifo_if.sv | 14 +
 rtl/uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Byte stream handshake between the UART receiver FIFO and its consumer.
//   out_valid : producer -> consumer, head byte is valid
//   out_data  : producer -> consumer, head byte
//   out_ready : consumer -> producer, head accepted when out_valid & out_ready
// master modport = producer (the receiver), slave modport = consumer.
interface uart_rx_fifo_if;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// circular byte FIFO that is drained over a valid/ready handshake.
// Ports:
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   rxd        : asynchronous serial line, idles high
//   rx_out     : uart_rx_fifo_if.master (out_valid / out_data / out_ready)
//   rx_busy    : frame FSM not in IDLE
//   frame_err  : one-cycle pulse, bad stop bit
//   parity_err : one-cycle pulse, parity mismatch (0 without the macro)
//   overrun    : one-cycle pulse, good byte dropped because the FIFO is full
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data).
module uart_rx_fifo #(
    parameter int BAUD       = 1152000,
    parameter int CLK_FREQ   = 90_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    uart_rx_fifo_if.master    rx_out,
    output logic              rx_busy,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);
    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Two-flop synchroniser plus one more stage for start-edge detection.
    logic sync1_reg, rxs, rxs_d_reg;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             byte_good, fe_next;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_reg, par_bad_next, pe_next;
`endif

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [7:0]  out_data_reg;
    logic        full, empty, pop, push, ov_next;
    logic        fe_reg, ov_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            rxs       <= 1'b1;
            rxs_d_reg <= 1'b1;
        end else begin
            sync1_reg <= rxd;
            rxs       <= sync1_reg;
            rxs_d_reg <= rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= par_bad_next;
`endif
        end
    end

    // Each non-idle state counts down to 0 and samples rxs on the zero cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        byte_good  = 1'b0;
        fe_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad_reg;
        pe_next      = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (rxs_d_reg && !rxs) begin
                    state_next = START;
                    cnt_next   = HALF_M1;
                end
            end
            START: begin
                if (cnt_reg == '0) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_next   = DIV_M1;
                        idx_next   = 3'd0;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
                    shift_next = {rxs, shift_reg[7:1]};
                    cnt_next   = DIV_M1;
                    if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_reg == '0) begin
                    // Even parity: data bits plus parity bit XOR to zero.
                    par_bad_next = rxs ^ (^shift_reg);
                    cnt_next     = DIV_M1;
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_reg == '0) begin
                    // Leave at mid-stop so a back-to-back start edge is caught.
                    state_next = IDLE;
                    if (!rxs) begin
                        fe_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_reg) begin
                        pe_next = 1'b1;
`endif
                    end else begin
                        byte_good = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop   = !empty && rx_out.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = byte_good && (!full || pop);
    assign ov_next = byte_good && full && !pop;
    assign rd_ptr_next = pop ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
        end
    end

    // Registered head read; a byte written to the slot that becomes the head
    // is forwarded so it is visible the cycle after the push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            out_data_reg <= '0;
            fe_reg       <= 1'b0;
            ov_reg       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            if (push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
                out_data_reg <= shift_reg;
            end else begin
                out_data_reg <= mem[rd_ptr_next[AW-1:0]];
            end
            fe_reg <= fe_next;
            ov_reg <= ov_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic pe_reg;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_reg <= 1'b0;
        end else begin
            pe_reg <= pe_next;
        end
    end
    assign parity_err = pe_reg;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_out.out_valid = !empty;
    assign rx_out.out_data  = out_data_reg;
    assign rx_busy          = (state_reg != IDLE);
    assign frame_err        = fe_reg;
    assign overrun          = ov_reg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int DIV = 78;
    // Start bit driven just after edge P0: rxs low at P2, FSM leaves IDLE at P3,
    // start check at P3+39, stop sample at P3+39+9*78 = P744 (+78 with parity),
    // out_valid visible after that edge.
`ifdef UART_RX_PARITY_EN
    localparam int SPAN = 822;
`else
    localparam int SPAN = 744;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic rx_busy, frame_err, parity_err, overrun;

    uart_rx_fifo_if bus ();

    uart_rx_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rx_out     (bus),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Monitor: observes on the falling edge, away from the active edge.
    logic [7:0] rx_q[$];
    int pop_cyc[$];
    int cyc = 0;
    int vcnt = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) vcnt++;
            if (bus.out_valid && bus.out_ready) begin
                rx_q.push_back(bus.out_data);
                pop_cyc.push_back(cyc);
                $display("rx byte %02h at cycle %0d", bus.out_data, cyc);
            end
            if (frame_err) fe_cnt++;
            if (parity_err) pe_cnt++;
            if (overrun) ov_cnt++;
        end
        cyc++;
    end

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_bit, input int gap);
        $display("tx byte %02h par_flip %b stop %b", d, par_flip, stop_bit);
        rxd = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (DIV) tick();
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        repeat (DIV) tick();
`endif
        rxd = stop_bit;
        repeat (DIV) tick();
        rxd = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd = 1'b1;
        bus.out_ready = 1'b0;
        repeat (5) tick();
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.out_data); else pass_cnt++;
        chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rx_busy); else pass_cnt++;
        chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_fe: got %b want 0", frame_err); else pass_cnt++;
        chk_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_pe: got %b want 0", parity_err); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ov: got %b want 0", overrun); else pass_cnt++;
        rst_n = 1'b1;
        repeat (3) tick();
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", rx_busy); else pass_cnt++;
    endtask

    task automatic test_latency();
        int base;
        logic v_before, v_after;
        base = rx_q.size();
        bus.out_ready = 1'b0;
        fork
            send_frame(8'h5A, 1'b0, 1'b1, 20);
            begin
                repeat (SPAN - 1) tick();
                v_before = bus.out_valid;
                tick();
                v_after = bus.out_valid;
            end
        join
        chk_cnt++; if (v_before !== 1'b0) $display("FAIL lat_before: got %b want 0", v_before); else pass_cnt++;
        chk_cnt++; if (v_after !== 1'b1) $display("FAIL lat_after: got %b want 1", v_after); else pass_cnt++;
        chk_cnt++; if (bus.out_data !== 8'h5A) $display("FAIL lat_head: got %h want 5a", bus.out_data); else pass_cnt++;
        bus.out_ready = 1'b1;
        repeat (5) tick();
        chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL lat_pops: got %0d want 1", rx_q.size() - base); else pass_cnt++;
    endtask

    task automatic test_single_byte();
        int base, v0, fe0, pe0, ov0;
        base = rx_q.size(); v0 = vcnt; fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        bus.out_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 40);
        chk_cnt++; if (vcnt - v0 !== 1) $display("FAIL single_beats: got %0d want 1", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL single_pops: got %0d want 1", rx_q.size() - base); else pass_cnt++;
        if (rx_q.size() > base) begin
            chk_cnt++; if (rx_q[base] !== 8'hA5) $display("FAIL single_data: got %h want a5", rx_q[base]); else pass_cnt++;
        end
        chk_cnt++; if ((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0) !== 0)
            $display("FAIL single_errs: got %0d want 0", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int base, fe0, pe0, ov0;
        logic busy_mid, busy_late, busy_done;
        base = rx_q.size(); fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        rxd = 1'b0;
        repeat (10) tick();
        busy_mid = rx_busy;
        repeat (10) tick();
        rxd = 1'b1;
        repeat (21) tick();          // now just after P41: START check not yet done
        busy_late = rx_busy;
        tick();                      // P42 = P3 + HALF: line high, back to IDLE
        busy_done = rx_busy;
        repeat (100) tick();
        chk_cnt++; if (busy_mid !== 1'b1) $display("FAIL glitch_busy_rise: got %b want 1", busy_mid); else pass_cnt++;
        chk_cnt++; if (busy_late !== 1'b1) $display("FAIL glitch_busy_hold: got %b want 1", busy_late); else pass_cnt++;
        chk_cnt++; if (busy_done !== 1'b0) $display("FAIL glitch_busy_fall: got %b want 0", busy_done); else pass_cnt++;
        chk_cnt++; if (rx_q.size() - base !== 0) $display("FAIL glitch_pops: got %0d want 0", rx_q.size() - base); else pass_cnt++;
        chk_cnt++; if ((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0) !== 0)
            $display("FAIL glitch_errs: got %0d want 0", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int base, fe0;
        base = rx_q.size(); fe0 = fe_cnt;
        bus.out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 100);
        chk_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
        chk_cnt++; if (rx_q.size() - base !== 0) $display("FAIL ferr_nopush: got %0d want 0", rx_q.size() - base); else pass_cnt++;
        send_frame(8'h55, 1'b0, 1'b1, 40);
        chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL ferr_next_pops: got %0d want 1", rx_q.size() - base); else pass_cnt++;
        if (rx_q.size() > base) begin
            chk_cnt++; if (rx_q[base] !== 8'h55) $display("FAIL ferr_next_data: got %h want 55", rx_q[base]); else pass_cnt++;
        end
        chk_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_next_clean: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
    endtask

    task automatic test_back_to_back_overrun();
        int base, ov0, nbad, span;
        base = rx_q.size(); ov0 = ov_cnt;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
        chk_cnt++; if (ov_cnt - ov0 !== 0) $display("FAIL ovr_early: got %0d want 0", ov_cnt - ov0); else pass_cnt++;
        send_frame(8'h10, 1'b0, 1'b1, 20);
        chk_cnt++; if (ov_cnt - ov0 !== 1) $display("FAIL ovr_pulse: got %0d want 1", ov_cnt - ov0); else pass_cnt++;
        chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL ovr_full_valid: got %b want 1", bus.out_valid); else pass_cnt++;
        bus.out_ready = 1'b1;
        repeat (30) tick();
        chk_cnt++; if (rx_q.size() - base !== 16) $display("FAIL ovr_drain_count: got %0d want 16", rx_q.size() - base); else pass_cnt++;
        nbad = 0;
        if (rx_q.size() - base == 16) begin
            for (int i = 0; i < 16; i++) if (rx_q[base + i] !== 8'(i)) nbad++;
            span = pop_cyc[base + 15] - pop_cyc[base];
            chk_cnt++; if (nbad !== 0) $display("FAIL ovr_order: got %0d wrong bytes want 0", nbad); else pass_cnt++;
            chk_cnt++; if (span !== 15) $display("FAIL ovr_throughput: got span %0d want 15", span); else pass_cnt++;
        end
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL ovr_empty: got %b want 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int base, fe0, pe0, ov0;
        logic busy_pre;
        base = rx_q.size(); fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        bus.out_ready = 1'b1;
        rxd = 1'b0;
        repeat (DIV) tick();
        rxd = 1'b1;
        repeat (4 * DIV + DIV / 2) tick();   // middle of data bit 4 of 0xFF
        busy_pre = rx_busy;
        rst_n = 1'b0;
        tick();
        chk_cnt++; if (busy_pre !== 1'b1) $display("FAIL rmid_busy_pre: got %b want 1", busy_pre); else pass_cnt++;
        chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", rx_busy); else pass_cnt++;
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.out_data !== 8'h00) $display("FAIL rmid_data: got %h want 00", bus.out_data); else pass_cnt++;
        rst_n = 1'b1;
        repeat (6 * DIV) tick();
        chk_cnt++; if (rx_q.size() - base !== 0) $display("FAIL rmid_nopush: got %0d want 0", rx_q.size() - base); else pass_cnt++;
        chk_cnt++; if ((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0) !== 0)
            $display("FAIL rmid_errs: got %0d want 0", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)); else pass_cnt++;
        chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL rmid_busy_end: got %b want 0", rx_busy); else pass_cnt++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int base, fe0, pe0;
        base = rx_q.size(); fe0 = fe_cnt; pe0 = pe_cnt;
        bus.out_ready = 1'b1;
        send_frame(8'h07, 1'b0, 1'b1, 40);   // parity bit 1: good
        chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL par_good_pops: got %0d want 1", rx_q.size() - base); else pass_cnt++;
        if (rx_q.size() > base) begin
            chk_cnt++; if (rx_q[base] !== 8'h07) $display("FAIL par_good_data: got %h want 07", rx_q[base]); else pass_cnt++;
        end
        send_frame(8'h07, 1'b1, 1'b1, 40);   // parity bit 0: bad
        chk_cnt++; if (pe_cnt - pe0 !== 1) $display("FAIL par_bad_pulse: got %0d want 1", pe_cnt - pe0); else pass_cnt++;
        chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL par_bad_nopush: got %0d want 1", rx_q.size() - base); else pass_cnt++;
        send_frame(8'h07, 1'b1, 1'b0, 100);  // parity and stop both bad
        chk_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL par_both_fe: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
        chk_cnt++; if (pe_cnt - pe0 !== 1) $display("FAIL par_both_pe: got %0d want 1", pe_cnt - pe0); else pass_cnt++;
    endtask
`endif

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_back_to_back_overrun();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
